// File: rtl/lcd_ctrl.sv
// HD44780-style character-LCD write sequencer: buffers LSU LCD words in a FIFO and replays each one as
// bus setup, EN pulse, hold and command-execution wait. Define LCD_INIT_EN for the power-up init sequence.
module lcd_ctrl #(
    parameter int FIFO_DEPTH  = 8,
    parameter int T_SETUP_CYC = 2,
    parameter int T_PW_CYC    = 12,
    parameter int T_HOLD_CYC  = 2,
    parameter int T_EXEC_CYC  = 2000,
    parameter int T_CLR_CYC   = 82000,
    parameter int T_PWRUP_CYC = 750000
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [31:0] i_lcd_data,
    input  logic        i_lcd_vld,
    output logic        o_full,
    output logic        o_busy,
    output logic        o_ovf,
    output logic        o_lcd_on,
    output logic        o_lcd_en,
    output logic        o_lcd_rs,
    output logic        o_lcd_rw,
    output logic [7:0]  o_lcd_data
);
    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam int T_MAX = max2(max2(max2(T_SETUP_CYC, T_PW_CYC), max2(T_HOLD_CYC, T_EXEC_CYC)),
                                max2(T_CLR_CYC, T_PWRUP_CYC));
    localparam int CW    = $clog2(T_MAX) + 1;

    localparam logic [CW-1:0] LD_SETUP = CW'(T_SETUP_CYC - 1);
    localparam logic [CW-1:0] LD_PW    = CW'(T_PW_CYC - 1);
    localparam logic [CW-1:0] LD_HOLD  = CW'(T_HOLD_CYC - 1);
    localparam logic [CW-1:0] LD_EXEC  = CW'(T_EXEC_CYC - 1);
    localparam logic [CW-1:0] LD_CLR   = CW'(T_CLR_CYC - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [AW:0]   PTR_ONE  = (AW + 1)'(1);

`ifdef LCD_INIT_EN
    localparam logic [CW-1:0] LD_PWRUP = CW'(T_PWRUP_CYC - 1);
    typedef enum logic [2:0] {S_IDLE, S_SETUP, S_PULSE, S_HOLD, S_WAIT, S_PWRUP, S_INIT} state_t;
`else
    typedef enum logic [2:0] {S_IDLE, S_SETUP, S_PULSE, S_HOLD, S_WAIT} state_t;
`endif

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [AW:0]     wr_ptr_q, rd_ptr_q;
    logic [8:0]      fifo_q [FIFO_DEPTH];
    logic            rs_q, rs_d;
    logic [7:0]      data_q, data_d;
    logic            en_q, on_q, ovf_q;
    logic            full, empty, push, pop, long_wait;
    logic            unused_bits;

    assign unused_bits = ^{i_lcd_data[30:10], i_lcd_data[8]};

    // Fullness is taken from the pointers before any pop in the same cycle.
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign push  = i_lcd_vld && !full;

    // Clear (0x01) and home (0x02/0x03) need the long execution wait.
    assign long_wait = !rs_q && ((data_q[7:1] == 7'b0000000 && data_q[0]) || data_q[7:1] == 7'b0000001);

`ifdef LCD_INIT_EN
    logic [2:0] idx_q, idx_d;

    function automatic logic [7:0] init_word(input logic [2:0] idx);
        case (idx)
            3'd0:    return 8'h38;
            3'd1:    return 8'h0C;
            3'd2:    return 8'h01;
            default: return 8'h06;
        endcase
    endfunction
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rs_d    = rs_q;
        data_d  = data_q;
        pop     = 1'b0;
`ifdef LCD_INIT_EN
        idx_d   = idx_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (!empty) begin
                    pop              = 1'b1;
                    {rs_d, data_d}   = fifo_q[rd_ptr_q[AW-1:0]];
                    state_d          = S_SETUP;
                    cnt_d            = LD_SETUP;
                end
            end
            S_SETUP: begin
                if (cnt_q == '0) begin
                    state_d = S_PULSE;
                    cnt_d   = LD_PW;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            S_PULSE: begin
                if (cnt_q == '0) begin
                    state_d = S_HOLD;
                    cnt_d   = LD_HOLD;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            S_HOLD: begin
                if (cnt_q == '0) begin
                    state_d = S_WAIT;
                    cnt_d   = long_wait ? LD_CLR : LD_EXEC;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            S_WAIT: begin
                if (cnt_q == '0) begin
`ifdef LCD_INIT_EN
                    state_d = (idx_q == 3'd4) ? S_IDLE : S_INIT;
`else
                    state_d = S_IDLE;
`endif
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
`ifdef LCD_INIT_EN
            S_PWRUP: begin
                if (cnt_q == '0) begin
                    state_d = S_INIT;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            S_INIT: begin
                rs_d    = 1'b0;
                data_d  = init_word(idx_q);
                idx_d   = idx_q + 3'd1;
                state_d = S_SETUP;
                cnt_d   = LD_SETUP;
            end
`endif
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (push) begin
            fifo_q[wr_ptr_q[AW-1:0]] <= {i_lcd_data[9], i_lcd_data[7:0]};
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
`ifdef LCD_INIT_EN
            state_q <= S_PWRUP;
            cnt_q   <= LD_PWRUP;
            idx_q   <= 3'd0;
`else
            state_q <= S_IDLE;
            cnt_q   <= '0;
`endif
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            rs_q     <= 1'b0;
            data_q   <= 8'h00;
            en_q     <= 1'b0;
            on_q     <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rs_q    <= rs_d;
            data_q  <= data_d;
            en_q    <= (state_d == S_PULSE);
`ifdef LCD_INIT_EN
            idx_q   <= idx_d;
`endif
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PTR_ONE;
                on_q     <= i_lcd_data[31];
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_ONE;
            end
            if (i_lcd_vld && full) begin
                ovf_q <= 1'b1;
            end
`ifdef LCD_INIT_EN
            // Panel power is forced on as power-up completes, overriding any same-cycle write.
            if (state_q == S_PWRUP && cnt_q == '0) begin
                on_q <= 1'b1;
            end
`endif
        end
    end

    assign o_full     = full;
    assign o_busy     = (state_q != S_IDLE) || !empty;
    assign o_ovf      = ovf_q;
    assign o_lcd_on   = on_q;
    assign o_lcd_en   = en_q;
    assign o_lcd_rs   = rs_q;
    assign o_lcd_rw   = 1'b0;
    assign o_lcd_data = data_q;
endmodule

// File: tb/tb_lcd_ctrl.sv
// Bench for lcd_ctrl: random and directed LCD writes checked every cycle against a timeline model
// (per-word start edge plus fixed phase lengths) and an ordered scoreboard of words seen on EN rising.
module tb_lcd_ctrl;
    localparam int DEPTH   = 4;
    localparam int T_SETUP = 2;
    localparam int T_PW    = 3;
    localparam int T_HOLD  = 2;
    localparam int T_EXEC  = 10;
    localparam int T_CLR   = 40;
    localparam int T_PWRUP = 20;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        vld = 1'b0;
    logic [31:0] din = 32'h0;
    logic        full, busy, ovf, lcd_on, lcd_en, lcd_rs, lcd_rw;
    logic [7:0]  lcd_data;

    always #5 clk = ~clk;

    lcd_ctrl #(
        .FIFO_DEPTH (DEPTH),
        .T_SETUP_CYC(T_SETUP),
        .T_PW_CYC   (T_PW),
        .T_HOLD_CYC (T_HOLD),
        .T_EXEC_CYC (T_EXEC),
        .T_CLR_CYC  (T_CLR),
        .T_PWRUP_CYC(T_PWRUP)
    ) dut (
        .i_clk     (clk),
        .i_rst_n   (rst_n),
        .i_lcd_data(din),
        .i_lcd_vld (vld),
        .o_full    (full),
        .o_busy    (busy),
        .o_ovf     (ovf),
        .o_lcd_on  (lcd_on),
        .o_lcd_en  (lcd_en),
        .o_lcd_rs  (lcd_rs),
        .o_lcd_rw  (lcd_rw),
        .o_lcd_data(lcd_data)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: timeline of the word currently being replayed.
    int         edge_n = 0;
    int         idle_edge, en_lo, en_hi, pwrup_end;
    logic [8:0] bus_m;
    logic       on_m, ovf_m, en_prev;
    bit         model_ok = 0;
    int         pulses = 0;
    logic [8:0] fifo_m [$];
    logic [8:0] init_m [$];
    logic [8:0] exp_q  [$];

    function automatic int wait_len(input logic [8:0] w);
        if (!w[8] && (w[7:0] == 8'h01 || w[7:0] == 8'h02 || w[7:0] == 8'h03)) return T_CLR;
        return T_EXEC;
    endfunction

    task automatic model_reset();
        fifo_m.delete();
        init_m.delete();
        exp_q.delete();
        bus_m     = 9'h0;
        on_m      = 1'b0;
        ovf_m     = 1'b0;
        en_lo     = 0;
        en_hi     = 0;
        en_prev   = 1'b0;
        idle_edge = edge_n;
        pwrup_end = -1;
`ifdef LCD_INIT_EN
        init_m    = '{9'h038, 9'h00C, 9'h001, 9'h006};
        exp_q     = '{9'h038, 9'h00C, 9'h001, 9'h006};
        idle_edge = edge_n + T_PWRUP;
        pwrup_end = edge_n + T_PWRUP;
`endif
        model_ok  = 1;
    endtask

    task automatic model_step();
        logic       full_pre;
        logic [8:0] w;
        bit         have;
        full_pre = (fifo_m.size() == DEPTH);
        have     = 0;
        if (edge_n >= idle_edge + 1) begin
            if (init_m.size() > 0) begin
                w = init_m.pop_front();
                have = 1;
            end else if (fifo_m.size() > 0) begin
                w = fifo_m.pop_front();
                have = 1;
            end
        end
        if (have) begin
            bus_m     = w;
            en_lo     = edge_n + T_SETUP;
            en_hi     = edge_n + T_SETUP + T_PW;
            idle_edge = edge_n + T_SETUP + T_PW + T_HOLD + wait_len(w);
        end
        if (vld) begin
            if (!full_pre) begin
                fifo_m.push_back({din[9], din[7:0]});
                exp_q.push_back({din[9], din[7:0]});
                on_m = din[31];
            end else begin
                ovf_m = 1'b1;
            end
        end
        if (edge_n == pwrup_end) on_m = 1'b1;
    endtask

    always @(posedge clk) begin
        edge_n++;
        if (!rst_n) model_reset();
        else if (model_ok) model_step();
        #1;
        if (model_ok) begin
            check("en",   lcd_en, (edge_n >= en_lo && edge_n < en_hi));
            check("rs",   lcd_rs, bus_m[8]);
            check("data", lcd_data, bus_m[7:0]);
            check("busy", busy, (edge_n < idle_edge) || fifo_m.size() > 0 || init_m.size() > 0);
            check("full", full, fifo_m.size() == DEPTH);
            check("ovf",  ovf, ovf_m);
            check("on",   lcd_on, on_m);
            check("rw",   lcd_rw, 1'b0);
            if (lcd_en === 1'b1 && en_prev !== 1'b1) begin
                pulses++;
                if (exp_q.size() == 0) check("en_unexpected", 1, 0);
                else check("en_word", {lcd_rs, lcd_data}, exp_q.pop_front());
            end
            en_prev = lcd_en;
        end
    end

    task automatic write(input logic [31:0] w);
        vld = 1'b1;
        din = w;
        @(negedge clk);
        vld = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int k = 0;
        while (busy !== 1'b0 && k < budget) begin
            @(negedge clk);
            k++;
        end
        check("idle_reached", busy, 0);
        @(negedge clk);
    endtask

    task automatic wait_en(input int budget);
        int k = 0;
        while (lcd_en !== 1'b1 && k < budget) begin
            @(negedge clk);
            k++;
        end
        check("en_seen", lcd_en, 1);
    endtask

    function automatic logic [31:0] rand_word();
        logic [7:0] b;
        b = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 3)) : 8'($urandom_range(0, 255));
        return {1'($urandom_range(0, 1)), 21'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), b};
    endfunction

    initial begin
        int p0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

`ifdef LCD_INIT_EN
        repeat (5) @(negedge clk);
        write(32'h8000_0255);
        wait_idle(1000);
        check("init_pulses", pulses, 5);
        check("init_on", lcd_on, 1);
`endif

        // Single data write
        write(32'h8000_0241);
        wait_idle(100);

        // Command waits: clear, normal, home
        write(32'h0000_0001);
        wait_idle(200);
        write(32'h0000_0038);
        wait_idle(200);
        write(32'h0000_0002);
        wait_idle(200);
        write(32'h0000_0003);
        wait_idle(200);

        // Six back-to-back strobes into a 4-deep FIFO
        p0 = pulses;
        for (int i = 0; i < 6; i++) write({1'b1, 21'h0, 1'b1, 1'b0, 8'($urandom_range(16, 255))});
        wait_idle(500);
        check("burst_pulses", pulses - p0, 5);
        check("burst_ovf", ovf, 1);

        // Write while EN is high
        write(32'h0000_0241);
        wait_en(50);
        write(32'h0000_0242);
        wait_idle(200);

        // Reset in the middle of a pulse
        write(32'h8000_0255);
        wait_en(50);
        p0 = pulses;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("rst_en", lcd_en, 0);
        check("rst_busy", busy, 0);
`ifndef LCD_INIT_EN
        repeat (60) @(negedge clk);
        check("rst_no_pulse", pulses - p0, 0);
`else
        wait_idle(1000);
`endif

        // Random traffic
        for (int n = 0; n < 60; n++) begin
            repeat ($urandom_range(0, 40)) @(negedge clk);
            if ($urandom_range(0, 4) == 0) begin
                for (int j = 0; j < int'($urandom_range(2, 6)); j++) write(rand_word());
            end else begin
                write(rand_word());
            end
        end
        wait_idle(5000);
        check("sb_drained", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
